// File: rtl/clock_div_monitor.sv
// Divided-clock monitor: edge pulses, period measurement, lock and loss detection on clk_in.
// Optional macro CLK_MON_GLITCH_FILTER_EN rejects synchronized levels held for only one cycle.
module clock_div_monitor #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 div_clk,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 lost
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 lvl_q;
    logic                 lvl_s;
    logic                 rise_det_d;
    logic                 rise_det_q;
    logic                 fall_det_d;
    logic                 fall_det_q;
`ifdef CLK_MON_GLITCH_FILTER_EN
    logic                 flt_q;
`endif
    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] period_q;
    logic [CNT_WIDTH-1:0] period_d;
    logic                 prev_vld_q;
    logic                 prev_vld_d;
    logic                 pv_d;
    logic                 rise_pulse_q;
    logic                 fall_pulse_q;
    logic                 pv_q;
    logic                 locked_q;
    logic                 lost_q;

    // Two-flop synchronizer followed by the accepted-level register and edge flags
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_q      <= 1'b0;
            rise_det_q <= 1'b0;
            fall_det_q <= 1'b0;
`ifdef CLK_MON_GLITCH_FILTER_EN
            flt_q      <= 1'b0;
`endif
        end else begin
            sync1_q    <= div_clk;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_s;
            rise_det_q <= rise_det_d;
            fall_det_q <= fall_det_d;
`ifdef CLK_MON_GLITCH_FILTER_EN
            flt_q      <= sync2_q;
`endif
        end
    end

    // A new level is accepted at once, or only after two equal synchronized samples when filtered
    always_comb begin
        lvl_s = lvl_q;
`ifdef CLK_MON_GLITCH_FILTER_EN
        if (sync2_q == flt_q) begin
            lvl_s = sync2_q;
        end else begin
            lvl_s = lvl_q;
        end
`else
        lvl_s = sync2_q;
`endif
        rise_det_d = lvl_s & ~lvl_q;
        fall_det_d = ~lvl_s & lvl_q;
    end

    // Period counter, lock FSM and timeout; a rise always beats a simultaneous timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        prev_vld_d = prev_vld_q;
        pv_d       = 1'b0;
        if (rise_det_q) begin
            cnt_d = CNT_ONE;
            case (state_q)
                ST_MEASURE, ST_LOCKED: begin
                    period_d   = cnt_q;
                    pv_d       = 1'b1;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q && (cnt_q == period_q)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end
                default: begin
                    state_d    = ST_MEASURE;
                    prev_vld_d = 1'b0;
                end
            endcase
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_q >= TIMEOUT_C) begin
                state_d    = ST_LOST;
                prev_vld_d = 1'b0;
            end else begin
                state_d = state_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_WIDTH{1'b0}};
            period_q     <= {CNT_WIDTH{1'b0}};
            prev_vld_q   <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            pv_q         <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            prev_vld_q   <= prev_vld_d;
            rise_pulse_q <= rise_det_q;
            fall_pulse_q <= fall_det_q;
            pv_q         <= pv_d;
            locked_q     <= (state_d == ST_LOCKED);
            lost_q       <= (state_d == ST_LOST);
        end
    end

    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Bench for clock_div_monitor: two instances (default-width/TIMEOUT=64 and 4-bit/TIMEOUT=15),
// an edge-history model compared every cycle, plus literal checks of the key scenarios.
module tb_clock_div_monitor;

`ifdef CLK_MON_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        div_a, div_b;
    logic        rise_a, fall_a, pv_a, lock_a, lost_a;
    logic [15:0] per_a;
    logic        rise_b, fall_b, pv_b, lock_b, lost_b;
    logic [3:0]  per_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_div_monitor #(.CNT_WIDTH(16), .TIMEOUT(64)) dut_a (
        .clk_in(clk), .rst(rst), .div_clk(div_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .period(per_a), .period_valid(pv_a), .locked(lock_a), .lost(lost_a));

    clock_div_monitor #(.CNT_WIDTH(4), .TIMEOUT(15)) dut_b (
        .clk_in(clk), .rst(rst), .div_clk(div_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .period(per_b), .period_valid(pv_b), .locked(lock_b), .lost(lost_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: accepted-level history, cycles since last rise, list of period updates
    int TOV[2]  = '{64, 15};
    int MAXV[2] = '{65535, 15};
    int m_e = 0;
    bit m_started = 1'b0;
    int m_ref[2];
    bit m_seen[2], m_lost[2], m_dprev[2];
    bit m_ah[2][5];
    int m_n[2], m_u0[2], m_u1[2];
    bit e_rise[2], e_fall[2], e_pv[2], e_lock[2], e_lost[2];
    int e_per[2];
    bit md, ma;
    int mcp;

    always @(posedge clk) begin
        m_e++;
        if (rst) m_started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            md = (i == 0) ? div_a : div_b;
            if (rst) begin
                m_ref[i] = m_e; m_seen[i] = 0; m_lost[i] = 0; m_dprev[i] = 0; m_n[i] = 0;
                for (int k = 0; k < 5; k++) m_ah[i][k] = 0;
                e_rise[i] = 0; e_fall[i] = 0; e_pv[i] = 0; e_lock[i] = 0; e_lost[i] = 0; e_per[i] = 0;
            end else begin
                if (FILT) ma = (md == m_dprev[i]) ? md : m_ah[i][0];
                else      ma = md;
                m_dprev[i] = md;
                for (int k = 4; k > 0; k--) m_ah[i][k] = m_ah[i][k-1];
                m_ah[i][0] = ma;
                e_rise[i] = m_ah[i][3] & ~m_ah[i][4];
                e_fall[i] = ~m_ah[i][3] & m_ah[i][4];
                mcp = m_e - 1 - m_ref[i];
                if (mcp > MAXV[i]) mcp = MAXV[i];
                e_pv[i] = 0;
                if (e_rise[i]) begin
                    if (m_seen[i] && !m_lost[i]) begin
                        e_per[i] = mcp; e_pv[i] = 1;
                        m_u1[i] = m_u0[i]; m_u0[i] = mcp; m_n[i]++;
                    end
                    m_seen[i] = 1; m_lost[i] = 0; m_ref[i] = m_e - 1;
                end else if (mcp >= TOV[i]) begin
                    m_lost[i] = 1; m_n[i] = 0;
                end
                e_lost[i] = m_lost[i];
                e_lock[i] = !m_lost[i] && (m_n[i] >= 2) && (m_u0[i] == m_u1[i]);
            end
        end
    end

    // Per-cycle comparison plus event logs used by the literal checks
    int cyc = 0, last_rise_cyc = -1, lost_delay = -1;
    bit lost_prev_a = 0, lost_seen_b = 0;
    int rise_cnt_a = 0, fall_cnt_a = 0;
    int log_per[$];
    int log_lock[$];

    always @(negedge clk) begin
        if (m_started) begin
            cyc++;
            chk("rise_a", rise_a, e_rise[0]);   chk("rise_b", rise_b, e_rise[1]);
            chk("fall_a", fall_a, e_fall[0]);   chk("fall_b", fall_b, e_fall[1]);
            chk("pv_a", pv_a, e_pv[0]);         chk("pv_b", pv_b, e_pv[1]);
            chk("period_a", per_a, e_per[0]);   chk("period_b", per_b, e_per[1]);
            chk("locked_a", lock_a, e_lock[0]); chk("locked_b", lock_b, e_lock[1]);
            chk("lost_a", lost_a, e_lost[0]);   chk("lost_b", lost_b, e_lost[1]);
            if (pv_a === 1'b1) begin
                log_per.push_back(int'(per_a));
                log_lock.push_back(int'(lock_a));
            end
            if (rise_a === 1'b1) begin
                last_rise_cyc = cyc;
                rise_cnt_a++;
            end
            if (fall_a === 1'b1) fall_cnt_a++;
            if (lost_a === 1'b1 && !lost_prev_a) lost_delay = cyc - last_rise_cyc;
            lost_prev_a = (lost_a === 1'b1);
            if (lost_b === 1'b1) lost_seen_b = 1'b1;
        end
    end

    function automatic int lp(input int idx);
        return (idx < log_per.size()) ? log_per[idx] : -1;
    endfunction
    function automatic int ll(input int idx);
        return (idx < log_lock.size()) ? log_lock[idx] : -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wave(input int which, input int per, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < per; c++) begin
                if (which == 0) div_a = (c < per / 2);
                else            div_b = (c < per / 2);
                tick();
            end
        end
    endtask

    int b, rc, fc;

    initial begin
        rst = 1'b1; div_a = 1'b0; div_b = 1'b0;
        repeat (10) tick();
        chk("reset period_a", per_a, 0);
        chk("reset locked_a", lock_a, 0);
        chk("reset lost_a", lost_a, 0);
        rst = 1'b0;

        // /16 from reset release: updates from the 2nd rise, lock at the 3rd
        b = log_per.size();
        wave(0, 16, 6);
        chk("div16 update count", log_per.size() - b, 5);
        chk("div16 first period", lp(b), 16);
        chk("div16 first locked", ll(b), 0);
        chk("div16 second period", lp(b + 1), 16);
        chk("div16 second locked", ll(b + 1), 1);

        // switch to /32: first 32 update unlocks, the next relocks
        b = log_per.size();
        wave(0, 32, 3);
        chk("div32 boundary period", lp(b), 16);
        chk("div32 first period", lp(b + 1), 32);
        chk("div32 first locked", ll(b + 1), 0);
        chk("div32 second period", lp(b + 2), 32);
        chk("div32 second locked", ll(b + 2), 1);

        // hold low: lost exactly TIMEOUT cycles after the last rise pulse
        div_a = 1'b0;
        repeat (80) tick();
        chk("timeout lost", lost_a, 1);
        chk("timeout locked", lock_a, 0);
        chk("timeout delay", lost_delay, 64);

        // restart /16 after loss: no update on the first rise
        b = log_per.size();
        wave(0, 16, 4);
        chk("restart first period", lp(b), 16);
        chk("restart first locked", ll(b), 0);
        chk("restart lost", lost_a, 0);
        chk("restart locked", lock_a, 1);

        // one-cycle reset while locked
        rst = 1'b1;
        tick();
        chk("rst pulse locked", lock_a, 0);
        chk("rst pulse period", per_a, 0);
        chk("rst pulse pv", pv_a, 0);
        rst = 1'b0;
        tick();
        chk("post rst rise", rise_a, 0);
        chk("post rst pv", pv_a, 0);
        b = log_per.size();
        wave(0, 16, 4);
        chk("relock after rst period", lp(b + 1), 16);
        chk("relock after rst locked", ll(b + 1), 1);

        // single-cycle high glitch on a low div_clk
        div_a = 1'b0;
        repeat (8) tick();
        rc = rise_cnt_a; fc = fall_cnt_a;
        div_a = 1'b1;
        tick();
        div_a = 1'b0;
        repeat (10) tick();
        chk("glitch rise count", rise_cnt_a - rc, FILT ? 0 : 1);
        chk("glitch fall count", fall_cnt_a - fc, FILT ? 0 : 1);

        // 4-bit counter: period 15 meets TIMEOUT=15 and the rise wins
        wave(1, 15, 4);
        chk("b div15 period", per_b, 15);
        chk("b div15 locked", lock_b, 1);
        chk("b div15 lost", lost_b, 0);
        lost_seen_b = 1'b0;
        // /20 exceeds the counter: loss declared, period never wraps
        wave(1, 20, 3);
        chk("b div20 lost seen", lost_seen_b, 1);
        chk("b div20 period", per_b, 15);
        chk("b div20 locked", lock_b, 0);

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
